// File: rtl/riscof_sig_dumper.sv
// Data-bus stage between the core dram port and the data RAM: passes core traffic
// through, snoops the host cells, and streams the signature region out after halt.
module riscof_sig_dumper #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  MEM_SIZE_WORDS = 1 << 19,
    parameter int  TIMEOUT        = 1000000,
    localparam int MAW            = $clog2(MEM_SIZE_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [3:0]            dram_we,
    input  logic                  dram_stb,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [DATA_WIDTH-1:0] dram_wdata,
    output logic [DATA_WIDTH-1:0] dram_rdata,
    output logic                  dram_ack,
    output logic                  dram_err,
    output logic [3:0]            mem_we,
    output logic                  mem_stb,
    output logic [MAW-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    input  logic                  mem_err,
    output logic [DATA_WIDTH-1:0] sig_data_o,
    output logic                  sig_valid_o,
    input  logic                  sig_ready_i,
    output logic                  halt_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  timeout_o
);

    localparam logic [MAW-1:0]        HALT_IDX   = MAW'(MEM_SIZE_WORDS - 3);
    localparam logic [MAW-1:0]        END_IDX    = MAW'(MEM_SIZE_WORDS - 2);
    localparam logic [MAW-1:0]        START_IDX  = MAW'(MEM_SIZE_WORDS - 1);
    localparam int                    CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(4);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_RD,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_start;
    logic [DATA_WIDTH-1:0] r_end;
    logic [DATA_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_sig_data;
    logic [CNT_W-1:0]      r_cyc_cnt;
    logic                  r_pending;
    logic                  r_halt;
    logic                  r_err;
    logic                  r_timeout;

    logic [MAW-1:0]        w_word_idx;
    logic                  w_store;
    logic                  w_halt_arm;
    logic                  w_drained;
    logic                  w_bad_region;
    logic [DATA_WIDTH-1:0] w_ptr_inc;
    logic                  w_set_err;
    logic                  w_set_timeout;
    logic                  w_load_ptr;
    logic                  w_adv_ptr;
    logic                  w_load_data;
    logic                  w_unused;

    assign w_word_idx   = dram_addr[MAW+1:2];
    assign w_store      = (r_state == S_RUN) && dram_stb && (dram_we == 4'hF);
    assign w_halt_arm   = w_store && (w_word_idx == HALT_IDX) && (dram_wdata == DATA_WIDTH'(1));
    // The halt store's own response may land in the same cycle the region is judged.
    assign w_drained    = !r_pending || mem_ack || mem_err;
    assign w_bad_region = (|r_start[1:0]) || (|r_end[1:0]) || (r_start > r_end);
    assign w_ptr_inc    = r_ptr + WORD_BYTES;
    assign w_unused     = ^{dram_addr[ADDR_WIDTH-1:MAW+2], dram_addr[1:0]};

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        mem_we        = 4'h0;
        mem_stb       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        dram_rdata    = '0;
        dram_ack      = 1'b0;
        dram_err      = 1'b0;
        w_set_err     = 1'b0;
        w_set_timeout = 1'b0;
        w_load_ptr    = 1'b0;
        w_adv_ptr     = 1'b0;
        w_load_data   = 1'b0;

        unique case (r_state)
            S_RUN: begin
                mem_we     = dram_we;
                mem_stb    = dram_stb;
                mem_addr   = w_word_idx;
                mem_wdata  = dram_wdata;
                dram_rdata = mem_rdata;
                dram_ack   = mem_ack;
                dram_err   = mem_err;
                if (w_halt_arm) begin
                    w_state_nxt = S_DRAIN;
                end else if (r_cyc_cnt == CNT_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_set_timeout = 1'b1;
                end
            end
            S_DRAIN: begin
                // Core strobes are dropped; only the halt store's response goes back.
                dram_rdata = mem_rdata;
                dram_ack   = mem_ack;
                dram_err   = mem_err;
                if (w_drained) begin
                    if (w_bad_region) begin
                        w_state_nxt = S_DONE;
                        w_set_err   = 1'b1;
                    end else if (r_start == r_end) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RD;
                        w_load_ptr  = 1'b1;
                    end
                end
            end
            S_RD: begin
                mem_stb     = 1'b1;
                mem_addr    = r_ptr[MAW+1:2];
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_err) begin
                    w_state_nxt = S_DONE;
                    w_set_err   = 1'b1;
                end else if (mem_ack) begin
                    w_state_nxt = S_OUT;
                    w_load_data = 1'b1;
                end
            end
            S_OUT: begin
                if (sig_ready_i) begin
                    w_adv_ptr   = 1'b1;
                    w_state_nxt = (w_ptr_inc == r_end) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state    <= S_RUN;
            r_start    <= '0;
            r_end      <= '0;
            r_ptr      <= '0;
            r_sig_data <= '0;
            r_cyc_cnt  <= '0;
            r_pending  <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_RUN) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            end

            if ((r_state == S_RUN) && dram_stb) begin
                r_pending <= 1'b1;
            end else if (((r_state == S_RUN) || (r_state == S_DRAIN)) && (mem_ack || mem_err)) begin
                r_pending <= 1'b0;
            end

            if (w_store && (w_word_idx == START_IDX)) begin
                r_start <= dram_wdata;
            end
            if (w_store && (w_word_idx == END_IDX)) begin
                r_end <= dram_wdata;
            end

            if (w_load_ptr) begin
                r_ptr <= r_start;
            end else if (w_adv_ptr) begin
                r_ptr <= w_ptr_inc;
            end

            if (w_load_data) begin
                r_sig_data <= mem_rdata;
            end

            if (w_halt_arm) begin
                r_halt <= 1'b1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign sig_data_o  = r_sig_data;
    assign sig_valid_o = (r_state == S_OUT);
    assign done_o      = (r_state == S_DONE);
    assign halt_o      = r_halt;
    assign err_o       = r_err;
    assign timeout_o   = r_timeout;

endmodule
